store_unit: RTL and testbench
=============================

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter XLEN, default 32, meaning: data/address width; legal values 32 and 64.
REQ-002 Derived constant BYTES = XLEN/8, meaning: byte lanes per memory word; OFFW = log2(BYTES).
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  store request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 store_type  input  2  00=SB, 01=SH, 10=SW, 11=SD (legal only when XLEN=64).
REQ-008 addr  input  XLEN  effective byte address.
REQ-009 write_data  input  XLEN  store data, LSB-justified.
REQ-010 mem_valid  output  1  memory beat present.
REQ-011 mem_ready  input  1  memory accepts beat.
REQ-012 mem_addr  output  XLEN  word-aligned beat address (low OFFW bits zero).
REQ-013 mem_wdata  output  XLEN  lane-aligned beat data.
REQ-014 mem_be  output  BYTES  active byte lanes.
REQ-015 misalign_err  output  1  one-cycle pulse: request rejected.
REQ-016 done  output  1  one-cycle pulse: final beat accepted.

Function
REQ-017 FSM states IDLE, BEAT0, BEAT1; req_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance = req_valid && req_ready; addr, write_data, store_type SHALL be registered on acceptance.
REQ-019 Access size SHALL be 1/2/4/8 bytes for SB/SH/SW/SD; offset = addr[OFFW-1:0].
REQ-020 Legal accepted request: next cycle state=BEAT0, mem_valid=1 (latency 1 cycle).
REQ-021 mem_addr/mem_wdata/mem_be SHALL hold stable while mem_valid && !mem_ready.
REQ-022 BEAT0: mem_addr = addr with low OFFW bits cleared; lanes offset..min(offset+size-1, BYTES-1) enabled; data = write_data << (8*offset); disabled lanes zero.
REQ-023 Access crossing word boundary (offset+size > BYTES): on BEAT0 handshake go BEAT1; mem_addr = BEAT0 addr + BYTES; lanes 0..(offset+size-BYTES-1); data = write_data >> (8*(BYTES-offset)); disabled lanes zero.
REQ-024 On handshake of final beat: done=1 for one cycle, mem_valid=0, state=IDLE next cycle.
REQ-025 store_type=11 with XLEN=32: misalign_err pulse cycle after acceptance, no mem_valid, return to IDLE.
REQ-026 Throughput: at most one request per (beats+1) cycles; no request accepted while a beat is pending.

Reset
REQ-027 On rst: state=IDLE, mem_valid=0, mem_be=0, mem_wdata=0, mem_addr=0, misalign_err=0, done=0, req_ready=1 the following cycle.
REQ-028 rst asserted mid-operation (BEAT0/BEAT1) SHALL abandon the store; no further beat, no done.

Configuration
REQ-029 Macro STORE_MISALIGN_SPLIT_EN defined: any misaligned store executes per REQ-022/023 (1 or 2 beats).
REQ-030 Macro undefined: request with addr not a multiple of size produces misalign_err pulse cycle after acceptance, no mem_valid, BEAT1 unreachable; aligned stores unaffected.

Structure
REQ-031 Package store_pkg SHALL hold store_type encodings, FSM state enum, and size-decode function.
REQ-032 Sub-module store_lane_shift SHALL be the combinational shift/mask (inputs size, offset, data, beat; outputs wdata, be); FSM and registers remain in store_unit.

Verification (XLEN=32 unless stated)
REQ-033 SB addr=0x1003 data=0xAABBCCDD, mem_ready=1 -> mem_addr=0x1000, mem_wdata=0xDD000000, mem_be=1000, done next cycle.
REQ-034 SW addr=0x2000 data=0x12345678, mem_ready low 3 cycles -> outputs stable 4 cycles, be=1111, single done after handshake.
REQ-035 SH addr=0x2003 data=0x00001234, macro defined -> beat0 addr 0x2000 wdata 0x34000000 be 1000; beat1 addr 0x2004 wdata 0x00000012 be 0001; done once.
REQ-036 Same stimulus, macro undefined -> misalign_err pulse, mem_valid never asserted, req_ready=1 following cycle.
REQ-037 rst asserted during BEAT1 of REQ-035 -> mem_valid=0 next cycle, no done, new SB accepted normally.
REQ-038 XLEN=64 SD addr=0x8 data=0x0102030405060708 -> mem_addr=0x8, be=0xFF, wdata unchanged; SD with XLEN=32 -> misalign_err.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types for the store unit: store-size encodings, FSM states and the
// size decode used by both the control path and the lane shifter.
package store_pkg;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10,
        ST_SD = 2'b11
    } store_type_e;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_e;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] st);
        return 4'(4'd1 << st);
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request-side and memory-side bundles of the store unit; the unit is the
// slave of the request bundle and the master of the memory bundle.
interface store_req_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      store_type;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] write_data;
    logic            misalign_err;
    logic            done;

    modport master (output req_valid, store_type, addr, write_data,
                    input  req_ready, misalign_err, done);
    modport slave  (input  req_valid, store_type, addr, write_data,
                    output req_ready, misalign_err, done);
endinterface

interface store_mem_if #(parameter int XLEN = 32);
    localparam int BYTES = XLEN / 8;

    logic             mem_valid;
    logic             mem_ready;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [BYTES-1:0] mem_be;

    modport master (output mem_valid, mem_addr, mem_wdata, mem_be,
                    input  mem_ready);
    modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_be,
                    output mem_ready);
endinterface

// File: rtl/store_lane_shift.sv
// Combinational lane placement: positions LSB-justified store data and its
// byte enables within the first (beat 0) or overflow (beat 1) memory word.
module store_lane_shift #(
    parameter int XLEN = 32,
    localparam int BYTES = XLEN / 8,
    localparam int OFFW  = $clog2(BYTES)
) (
    input  logic [3:0]       size_i,
    input  logic [OFFW-1:0]  offset_i,
    input  logic [XLEN-1:0]  data_i,
    input  logic             beat_i,
    output logic [XLEN-1:0]  wdata_o,
    output logic [BYTES-1:0] be_o
);
    localparam int SPW = 2 * BYTES;

    logic [SPW-1:0]    span;
    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   bit_mask;

    // The access is laid out across two adjacent words; beat 1 takes the upper word.
    always_comb begin
        // NOTE: every output and temporary gets a value on every pass, so no latch is inferred.
        bit_mask = '0;
        span     = SPW'((16'd1 << size_i) - 16'd1) << offset_i;
        shifted  = {{XLEN{1'b0}}, data_i} << {offset_i, 3'b000};
        be_o     = beat_i ? span[SPW-1:BYTES] : span[BYTES-1:0];
        for (int i = 0; i < BYTES; i++) begin
            bit_mask[8*i +: 8] = {8{be_o[i]}};
        end
        wdata_o = (beat_i ? shifted[2*XLEN-1:XLEN] : shifted[XLEN-1:0]) & bit_mask;
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: turns byte/half/word/double stores into one or two lane-aligned
// memory beats. Build option STORE_MISALIGN_SPLIT_EN enables split misaligned stores.
module store_unit
    import store_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    store_req_if.slave   req,
    store_mem_if.master  mem
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(BYTES - 1));

    state_e           state_q;
    store_type_e      type_q;
    logic [XLEN-1:0]  addr_q, data_q;
    logic             mem_valid_q, err_q, done_q;
    logic [XLEN-1:0]  mem_addr_q, mem_wdata_q;
    logic [BYTES-1:0] mem_be_q;

    logic             accept, req_illegal, cross_q;
    logic [3:0]       req_size, size_q, sh_size;
    logic [OFFW-1:0]  sh_off;
    logic [XLEN-1:0]  sh_data, sh_wdata;
    logic [BYTES-1:0] sh_be;
    logic             sh_beat;

    always_comb begin
        accept   = req.req_valid && (state_q == IDLE);
        req_size = size_bytes(req.store_type);
        size_q   = size_bytes(type_q);
        cross_q  = (int'(addr_q[OFFW-1:0]) + int'(size_q)) > BYTES;
`ifdef STORE_MISALIGN_SPLIT_EN
        req_illegal = (XLEN == 32) && (req.store_type == ST_SD);
`else
        req_illegal = ((XLEN == 32) && (req.store_type == ST_SD))
                   || ((req.addr[3:0] & (req_size - 4'd1)) != 4'd0);
`endif
        // In IDLE the shifter prepares beat 0 of the incoming request; otherwise beat 1 of the held one.
        sh_beat = (state_q != IDLE);
        sh_size = sh_beat ? size_q : req_size;
        sh_off  = sh_beat ? addr_q[OFFW-1:0] : req.addr[OFFW-1:0];
        sh_data = sh_beat ? data_q : req.write_data;
    end

    store_lane_shift #(.XLEN(XLEN)) u_shift (
        .size_i   (sh_size),
        .offset_i (sh_off),
        .data_i   (sh_data),
        .beat_i   (sh_beat),
        .wdata_o  (sh_wdata),
        .be_o     (sh_be)
    );

    // NOTE: request capture registers carry no reset; they are only read after a load on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= req.addr;
            data_q <= req.write_data;
            type_q <= store_type_e'(req.store_type);
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (accept) begin
                    if (req_illegal) begin
                        err_q <= 1'b1;
                    end else begin
                        state_q     <= BEAT0;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= req.addr & WORD_MASK;
                        mem_wdata_q <= sh_wdata;
                        mem_be_q    <= sh_be;
                    end
                end
                BEAT0: if (mem.mem_ready) begin
                    if (cross_q) begin
                        state_q     <= BEAT1;
                        mem_addr_q  <= (addr_q & WORD_MASK) + XLEN'(BYTES);
                        mem_wdata_q <= sh_wdata;
                        mem_be_q    <= sh_be;
                    end else begin
                        state_q     <= IDLE;
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                BEAT1: if (mem.mem_ready) begin
                    state_q     <= IDLE;
                    mem_valid_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req.req_ready    = (state_q == IDLE);
    assign req.misalign_err = err_q;
    assign req.done         = done_q;
    assign mem.mem_valid    = mem_valid_q;
    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_wdata    = mem_wdata_q;
    assign mem.mem_be       = mem_be_q;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: a byte-level reference model drives a
// per-cycle compare on the XLEN=32 instance; directed literals pin both sizes.
module tb_store_unit;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } beat_t;

    typedef struct {
        bit    illegal;
        int    n;
        beat_t b0;
        beat_t b1;
    } plan_t;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_req_if #(.XLEN(32)) r32 ();
    store_mem_if #(.XLEN(32)) m32 ();
    store_req_if #(.XLEN(64)) r64 ();
    store_mem_if #(.XLEN(64)) m64 ();

    store_unit #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .req(r32.slave), .mem(m32.master));
    store_unit #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .req(r64.slave), .mem(m64.master));

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: each byte k of the store lands at byte position offset+k
    // of a two-word window; positions past the first word belong to beat 1.
    function automatic plan_t plan(input int nbytes, input bit split, input logic [1:0] st,
                                   input logic [63:0] a, input logic [63:0] d);
        plan_t p;
        int size, off, pos;
        size      = 1 << st;
        off       = int'(a % 64'(nbytes));
        p.illegal = (st == 2'b11 && nbytes == 4) || (!split && (a % 64'(size)) != 64'd0);
        p.n       = (off + size > nbytes) ? 2 : 1;
        p.b0.addr = a - 64'(off);
        p.b1.addr = p.b0.addr + 64'(nbytes);
        p.b0.data = '0; p.b0.be = '0;
        p.b1.data = '0; p.b1.be = '0;
        for (int k = 0; k < size; k++) begin
            pos = off + k;
            if (pos < nbytes) begin
                p.b0.be[pos]          = 1'b1;
                p.b0.data[8*pos +: 8] = d[8*k +: 8];
            end else begin
                p.b1.be[pos-nbytes]            = 1'b1;
                p.b1.data[8*(pos-nbytes) +: 8] = d[8*k +: 8];
            end
        end
        return p;
    endfunction

    // Per-cycle compare of the XLEN=32 instance against the model.
    beat_t exp_q[$];
    bit    chk_en = 0;
    bit    m_idle = 1, nxt_done = 0, nxt_err = 0;

    always @(negedge clk) begin
        bit    cur_done, cur_err;
        plan_t p;
        if (chk_en) begin
            cur_done = nxt_done;
            cur_err  = nxt_err;
            nxt_done = 0;
            nxt_err  = 0;
            if (cur_done) m_idle = 1;
            check("req_ready",    64'(r32.req_ready),    64'(m_idle));
            check("done",         64'(r32.done),         64'(cur_done));
            check("misalign_err", 64'(r32.misalign_err), 64'(cur_err));
            check("mem_valid",    64'(m32.mem_valid),    64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("mem_addr",  64'(m32.mem_addr),  exp_q[0].addr);
                check("mem_wdata", 64'(m32.mem_wdata), exp_q[0].data);
                check("mem_be",    64'(m32.mem_be),    64'(exp_q[0].be));
            end
            if (rst) begin
                exp_q.delete();
                m_idle = 1;
            end else begin
                if (exp_q.size() != 0 && m32.mem_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) nxt_done = 1;
                end
                if (r32.req_valid && m_idle) begin
                    p = plan(4, SPLIT, r32.store_type, 64'(r32.addr), 64'(r32.write_data));
                    if (p.illegal) nxt_err = 1;
                    else begin
                        exp_q.push_back(p.b0);
                        if (p.n == 2) exp_q.push_back(p.b1);
                        m_idle = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready32();
        for (int i = 0; i < 50 && r32.req_ready !== 1'b1; i++) step();
        if (r32.req_ready !== 1'b1) check("ready_timeout", 64'(r32.req_ready), 64'd1);
    endtask

    task automatic send32(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
        wait_ready32();
        r32.req_valid  = 1'b1;
        r32.store_type = st;
        r32.addr       = a;
        r32.write_data = d;
        step();
        r32.req_valid  = 1'b0;
    endtask

    vec_t  vecs[6];
    plan_t pm;

    initial begin
        r32.req_valid = 1'b0; r32.store_type = 2'b00; r32.addr = '0; r32.write_data = '0;
        r64.req_valid = 1'b0; r64.store_type = 2'b00; r64.addr = '0; r64.write_data = '0;
        m32.mem_ready = 1'b1;
        m64.mem_ready = 1'b1;

        // Model pins against hand-computed values.
        pm = plan(4, 1'b1, 2'b01, 64'h2003, 64'h1234);
        check("model_sh_b0_data", pm.b0.data, 64'h3400_0000);
        check("model_sh_b0_be",   64'(pm.b0.be), 64'h8);
        check("model_sh_b1_addr", pm.b1.addr, 64'h2004);
        check("model_sh_b1_data", pm.b1.data, 64'h12);
        check("model_sh_beats",   64'(pm.n), 64'd2);
        pm = plan(4, 1'b0, 2'b01, 64'h2003, 64'h1234);
        check("model_sh_nosplit_illegal", 64'(pm.illegal), 64'd1);

        // Reset state.
        step(); step(); step();
        rst = 1'b0;
        check("rst_mem_valid", 64'(m32.mem_valid), 64'd0);
        check("rst_mem_be",    64'(m32.mem_be),    64'd0);
        check("rst_mem_wdata", 64'(m32.mem_wdata), 64'd0);
        check("rst_mem_addr",  64'(m32.mem_addr),  64'd0);
        check("rst_err",       64'(r32.misalign_err), 64'd0);
        check("rst_done",      64'(r32.done),      64'd0);
        check("rst_ready",     64'(r32.req_ready), 64'd1);
        chk_en = 1;

        // SB at the top byte lane.
        send32(2'b00, 32'h1003, 32'hAABBCCDD);
        check("sb_valid", 64'(m32.mem_valid), 64'd1);
        check("sb_addr",  64'(m32.mem_addr),  64'h1000);
        check("sb_wdata", 64'(m32.mem_wdata), 64'hDD00_0000);
        check("sb_be",    64'(m32.mem_be),    64'h8);
        step();
        check("sb_done", 64'(r32.done), 64'd1);

        // SW held under three stall cycles.
        m32.mem_ready = 1'b0;
        send32(2'b10, 32'h2000, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m32.mem_ready = 1'b1;
            check("sw_stall_addr",  64'(m32.mem_addr),  64'h2000);
            check("sw_stall_wdata", 64'(m32.mem_wdata), 64'h1234_5678);
            check("sw_stall_be",    64'(m32.mem_be),    64'hF);
            check("sw_stall_done",  64'(r32.done),      64'd0);
            step();
        end
        check("sw_done", 64'(r32.done), 64'd1);
        step();

        // SH crossing a word boundary.
        send32(2'b01, 32'h2003, 32'h00001234);
`ifdef STORE_MISALIGN_SPLIT_EN
        check("sh_b0_addr",  64'(m32.mem_addr),  64'h2000);
        check("sh_b0_wdata", 64'(m32.mem_wdata), 64'h3400_0000);
        check("sh_b0_be",    64'(m32.mem_be),    64'h8);
        step();
        check("sh_b1_addr",  64'(m32.mem_addr),  64'h2004);
        check("sh_b1_wdata", 64'(m32.mem_wdata), 64'h12);
        check("sh_b1_be",    64'(m32.mem_be),    64'h1);
        step();
        check("sh_done", 64'(r32.done), 64'd1);
`else
        check("sh_err",   64'(r32.misalign_err), 64'd1);
        check("sh_valid", 64'(m32.mem_valid),    64'd0);
        check("sh_ready", 64'(r32.req_ready),    64'd1);
        step();
        check("sh_err_pulse", 64'(r32.misalign_err), 64'd0);
`endif
        step();

        // Reset in the middle of a store, then a fresh SB.
        m32.mem_ready = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        send32(2'b01, 32'h2003, 32'h00001234);
        m32.mem_ready = 1'b1;
        step();
        check("mid_b1_addr", 64'(m32.mem_addr), 64'h2004);
`else
        send32(2'b10, 32'h2000, 32'h12345678);
`endif
        check("mid_valid", 64'(m32.mem_valid), 64'd1);
        rst = 1'b1;
        m32.mem_ready = 1'b0;
        step();
        rst = 1'b0;
        check("abandon_valid", 64'(m32.mem_valid), 64'd0);
        check("abandon_done",  64'(r32.done),      64'd0);
        step();
        check("abandon_done2", 64'(r32.done), 64'd0);
        m32.mem_ready = 1'b1;
        send32(2'b00, 32'h3001, 32'h00000055);
        check("post_rst_addr",  64'(m32.mem_addr),  64'h3000);
        check("post_rst_wdata", 64'(m32.mem_wdata), 64'h0000_5500);
        check("post_rst_be",    64'(m32.mem_be),    64'h2);
        step();
        check("post_rst_done", 64'(r32.done), 64'd1);

        // Model-checked sweep with an alternating ready pattern.
        vecs[0] = '{2'b00, 32'h1000, 32'h00000011};
        vecs[1] = '{2'b01, 32'h1002, 32'h0000BEEF};
        vecs[2] = '{2'b10, 32'h1001, 32'hCAFEF00D};
        vecs[3] = '{2'b01, 32'h1001, 32'h00007788};
        vecs[4] = '{2'b11, 32'h1000, 32'h00000001};
        vecs[5] = '{2'b10, 32'h1004, 32'hFFFFFFFF};
        foreach (vecs[v]) begin
            send32(vecs[v].st, vecs[v].addr, vecs[v].data);
            for (int j = 0; j < 8; j++) begin
                m32.mem_ready = (j % 2 == 1);
                step();
            end
            m32.mem_ready = 1'b1;
            wait_ready32();
        end
        step();
        send32(2'b11, 32'h0008, 32'h05060708);
        check("sd32_err", 64'(r32.misalign_err), 64'd1);
        step();

        // XLEN=64 instance.
        r64.req_valid = 1'b1; r64.store_type = 2'b11;
        r64.addr = 64'h8; r64.write_data = 64'h0102030405060708;
        step();
        r64.req_valid = 1'b0;
        pm = plan(8, SPLIT, 2'b11, 64'h8, 64'h0102030405060708);
        check("sd64_valid", 64'(m64.mem_valid), 64'd1);
        check("sd64_addr",  m64.mem_addr,  64'h8);
        check("sd64_be",    64'(m64.mem_be), 64'hFF);
        check("sd64_wdata", m64.mem_wdata, 64'h0102030405060708);
        check("sd64_model", m64.mem_wdata, pm.b0.data);
        step();
        check("sd64_done", 64'(r64.done), 64'd1);
        r64.req_valid = 1'b1; r64.store_type = 2'b10;
        r64.addr = 64'h1C; r64.write_data = 64'h00000000DEADBEEF;
        step();
        r64.req_valid = 1'b0;
        check("sw64_addr",  m64.mem_addr,  64'h18);
        check("sw64_be",    64'(m64.mem_be), 64'hF0);
        check("sw64_wdata", m64.mem_wdata, 64'hDEADBEEF_00000000);
        step();
        check("sw64_done", 64'(r64.done), 64'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
